// File: rtl/char_stim_pkg.sv
// Shared types for the character stimulus generator: FSM state and serve mode.
package char_stim_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

endpackage

// File: rtl/char_stim_gen_if.sv
// Request/preset/output bus of char_stim_gen; master drives requests, slave emits values.
// Handshake: a request is taken when req & req_ready; a beat is consumed when out_valid & out_ready.
interface char_stim_gen_if #(
  parameter int WIDTH = 24,
  parameter int CW    = 1
);
  logic             req;
  logic             req_ready;
  logic             mode;
  logic [CW-1:0]    sel_ch;
  logic             load_en;
  logic [CW-1:0]    load_ch;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_ch;
  logic             out_valid;
  logic             out_wrap;
  logic             out_ready;

  modport master (
    output req, mode, sel_ch, load_en, load_ch, load_val, out_ready,
    input  req_ready, out_data, out_ch, out_valid, out_wrap
  );

  modport slave (
    input  req, mode, sel_ch, load_en, load_ch, load_val, out_ready,
    output req_ready, out_data, out_ch, out_valid, out_wrap
  );
endinterface

// File: rtl/char_stim_chan.sv
// One channel counter: windowed increment with wrap flag, preset has priority over increment.
module char_stim_chan #(
  parameter int               WIDTH    = 24,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               STEP     = 1,
  parameter int               LO_LIMIT = 32,
  parameter int               HI_LIMIT = 126
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_val,
  output logic             o_wrapped
);
  logic [WIDTH-1:0] r_val;
  logic             r_wrapped;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrapped_sum;
  logic             w_wrap;

  assign w_sum         = {1'b0, r_val} + (WIDTH+1)'(STEP);
  assign w_wrap        = w_sum > (WIDTH+1)'(HI_LIMIT);
  assign w_wrapped_sum = (WIDTH+1)'(LO_LIMIT) + w_sum - (WIDTH+1)'(HI_LIMIT) - (WIDTH+1)'(1);

  // r_wrapped describes the value currently held, so it travels out with that value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_val     <= RST_VAL;
      r_wrapped <= 1'b0;
    end else if (i_load) begin
      r_val     <= i_load_val;
      r_wrapped <= 1'b0;
    end else if (i_inc) begin
      r_val     <= w_wrap ? w_wrapped_sum[WIDTH-1:0] : w_sum[WIDTH-1:0];
      r_wrapped <= w_wrap;
    end
  end

  assign o_val     = r_val;
  assign o_wrapped = r_wrapped;
endmodule

// File: rtl/char_stim_gen.sv
// Multi-channel character stimulus generator with round-robin or fixed channel serving.
module char_stim_gen
  import char_stim_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int NUM_CH   = 2,
  parameter int BASE     = 94,
  parameter int SPACING  = 3,
  parameter int STEP     = 1,
  parameter int LO_LIMIT = 32,
  parameter int HI_LIMIT = 126
) (
  input  logic           clock,
  input  logic           reset,
  char_stim_gen_if.slave bus,
  output state_t         o_state
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t           r_state;
  logic [CW-1:0]    r_rr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_ch;
  logic             r_out_wrap;

  logic             w_fixed;
  logic [CW-1:0]    w_serve_ch;
  logic             w_ch_ok;
  logic             w_accept;
  logic [WIDTH-1:0] w_val [NUM_CH];
  logic             w_wrapped [NUM_CH];
  logic [WIDTH-1:0] w_sel_val;
  logic             w_sel_wrap;

  assign w_fixed        = mode_t'(bus.mode) == MODE_FIXED;
  assign w_serve_ch     = w_fixed ? bus.sel_ch : r_rr;
  assign w_ch_ok        = {1'b0, w_serve_ch} < (CW+1)'(NUM_CH);
  assign bus.req_ready  = (r_state == ST_IDLE) | bus.out_ready;
  assign w_accept       = bus.req & bus.req_ready & w_ch_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [WIDTH:0] RV = (WIDTH+1)'(BASE) + (WIDTH+1)'(i * SPACING);
    char_stim_chan #(
      .WIDTH    (WIDTH),
      .RST_VAL  (RV[WIDTH-1:0]),
      .STEP     (STEP),
      .LO_LIMIT (LO_LIMIT),
      .HI_LIMIT (HI_LIMIT)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .i_inc      (w_accept && (w_serve_ch == CW'(i))),
      .i_load     (bus.load_en && (bus.load_ch == CW'(i))),
      .i_load_val (bus.load_val),
      .o_val      (w_val[i]),
      .o_wrapped  (w_wrapped[i])
    );
  end

  // Decoded select keeps an out-of-range channel number from indexing past the array.
  always_comb begin
    w_sel_val  = '0;
    w_sel_wrap = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_serve_ch == CW'(i)) begin
        w_sel_val  = w_val[i];
        w_sel_wrap = w_wrapped[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rr        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_wrap  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_HOLD;
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_val;
      r_out_ch    <= w_serve_ch;
      r_out_wrap  <= w_sel_wrap;
      if (!w_fixed) r_rr <= (r_rr == CW'(NUM_CH - 1)) ? '0 : r_rr + 1'b1;
    end else if (bus.out_ready) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_wrap  = r_out_wrap;
  assign o_state       = r_state;
endmodule

// File: tb/tb_char_stim_gen.sv
// Bench for char_stim_gen: vector table plus hand sequences, beats checked through an expected queue.
module tb_char_stim_gen;
  import char_stim_pkg::*;

  localparam int WIDTH = 24;
  localparam int CW    = 1;
  localparam int BW    = WIDTH + CW + 1;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  state_t state;
  int     n_vec  = 0;
  int     n_miss = 0;
  logic [BW-1:0] exp_q[$];

  char_stim_gen_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  char_stim_gen dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             mode;
    logic [CW-1:0]    sel;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    ch;
    logic             wrap;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic [CW-1:0] c, input logic w);
    exp_q.push_back({d, c, w});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = 1'b0; bus.mode = 1'b0; bus.sel_ch = '0;
    bus.load_en = 1'b0; bus.load_ch = '0; bus.load_val = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    int k;
    bus.req = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    step();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every consumed beat is matched against the oldest expected beat.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_beat: got data %0d ch %0d, expected no beat", bus.out_data, bus.out_ch);
      end else begin
        logic [BW-1:0] e;
        e = exp_q.pop_front();
        check("beat_data", bus.out_data, e[BW-1 -: WIDTH]);
        check("beat_ch", bus.out_ch, e[CW:1]);
        check("beat_wrap", bus.out_wrap, e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    vecs[0] = '{1'b1, 1'b1, 24'd97, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'd98, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 24'd99, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 24'd94, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'd100, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 24'd95, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 24'd96, 1'b0, 1'b0};

    // Reset state
    step();
    @(negedge clock);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_ch", bus.out_ch, 0);
    check("rst_wrap", bus.out_wrap, 0);
    check("rst_state", state, ST_IDLE);
    check("rst_req_ready", bus.req_ready, 1);
    reset = 1'b1;
    step();

    // Round-robin back-to-back
    push(94, 0, 0); push(97, 1, 0); push(95, 0, 0); push(98, 1, 0);
    bus.req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drain("rr_drain");

    // Table of single requests, fixed and round-robin mixed
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.mode = vecs[i].mode;
      bus.sel_ch = vecs[i].sel;
      bus.req = 1'b1;
      push(vecs[i].data, vecs[i].ch, vecs[i].wrap);
      step();
    end
    drain("table_drain");

    // Preset to the top of the window, then wrap
    do_reset();
    bus.load_en = 1'b1; bus.load_ch = 1'b0; bus.load_val = 24'd126;
    step();
    bus.load_en = 1'b0;
    bus.mode = 1'b1; bus.sel_ch = 1'b0; bus.req = 1'b1;
    push(126, 0, 0); push(32, 0, 1); push(33, 0, 0);
    step(); step(); step();
    drain("wrap_drain");

    // Backpressure: held beat, requests refused
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 1'b1;
    push(94, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, 94);
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_state", state, ST_HOLD);
      step();
    end
    bus.out_ready = 1'b1;
    push(97, 1, 0);
    step();
    bus.out_ready = 1'b0;
    bus.req = 1'b0;
    @(negedge clock);
    check("hold2_data", bus.out_data, 97);
    check("hold2_ch", bus.out_ch, 1);
    step();
    drain("bp_drain");

    // Asynchronous reset while holding
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_state", state, ST_IDLE);
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    push(94, 0, 0); push(97, 1, 0);
    bus.req = 1'b1;
    step(); step();
    drain("arst_drain");

    // Preset coinciding with an accept on the same channel
    do_reset();
    bus.mode = 1'b1; bus.sel_ch = 1'b0; bus.req = 1'b1;
    bus.load_en = 1'b1; bus.load_ch = 1'b0; bus.load_val = 24'd50;
    push(94, 0, 0);
    step();
    bus.load_en = 1'b0;
    push(50, 0, 0);
    step();
    drain("load_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
